sap1_sequencer: RTL and testbench
=================================

# sap1_sequencer

Instruction sequencer and control-word decoder for the SAP-1 datapath. It steps through fetch and execute micro-steps (T0–T4), decodes the 4-bit opcode held in the instruction register, and drives the load/output-enable strobes for the datapath registers, RAM, ALU, program counter and output register. All strobes are qualified downstream by `mclk_en`. The sequencer is the sole source of `i_load_enable` for every datapath register.

## Interface
- `STEP_W`, 3: width of the step counter and of `o_step`.
- `mclk`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `mclk_en`  input  1  clock enable; state advances only on edges where it is high.
- `i_opcode`  input  4  instruction register high nibble; used only in T2–T4.
- `i_carry`, `i_zero`  input  1 each  flags-register outputs.
- `o_co` / `o_mi` / `o_ro` / `o_ri` / `o_ii` / `o_io`  output  1 each  PC out, MAR in, RAM out, RAM in, IR in, IR operand out.
- `o_ai` / `o_ao` / `o_bi` / `o_eo` / `o_su` / `o_fi`  output  1 each  A in, A out, B in, ALU out, ALU subtract, flags in.
- `o_ce` / `o_j` / `o_oi`  output  1 each  PC count enable, PC load, output-register in.
- `o_hlt`  output  1  halted; stops the datapath.
- `o_step`  output  `STEP_W`  current micro-step, for debug/display.

## Operation
- State: step counter `step` (0–4) and halt flag `halted`. Control outputs are combinational from `step`, `i_opcode`, flags and `halted`.
- Fetch, every instruction: T0 = co, mi. T1 = ro, ii, ce.
- Execute (T2, T3, T4); the listed length includes T0/T1:
  - 0001 LDA (4): T2 io, mi. T3 ro, ai.
  - 0010 ADD (5): T2 io, mi. T3 ro, bi. T4 eo, ai, fi.
  - 0011 SUB (5): same as ADD; su also asserted in T4 only.
  - 0100 STA (4): T2 io, mi. T3 ao, ri.
  - 0101 LDI (3): T2 io, ai.
  - 0110 JMP (3): T2 io, j.
  - 0111 JC (3): T2 io; j only if `i_carry`=1.
  - 1000 JZ (3): T2 io; j only if `i_zero`=1.
  - 1110 OUT (3): T2 ao, oi.
  - 1111 HLT (3): T2 hlt; sets `halted`.
  - 0000 and all other codes: NOP (3); T2 has an all-zero control word.
- Step advance, on an edge with `mclk_en`=1 and not halted:
  - If `step` is the last step of the current opcode, `step` goes to 0.
  - Otherwise `step` increments.
  - The last step is 1 less than the length. T0/T1 never terminate.
- Halt:
  - `halted` is set on the `mclk_en` edge that leaves T2 of HLT; `step` goes to 0 on that edge.
  - While halted, `step` is frozen, `o_hlt`=1, and every other output is 0.
  - Only `reset` clears `halted`.
- Flags: `i_carry`/`i_zero` are sampled combinationally during T2. Jump-not-taken still ends after T2.
- `reset` is honoured on every `mclk` edge regardless of `mclk_en`: `step`=0, `halted`=0.
- Reset mid-instruction abandons it; no partial strobes persist.

## Timing
- Reset values, after the reset edge: `o_step`=0, `o_hlt`=0, `o_co`=`o_mi`=1, all other outputs 0. This is the T0 word.
- Outputs change only after a state-changing `mclk` edge, or combinationally with `i_opcode`/flags in T2–T4.
- Consumers load on the same `mclk_en` edge that ends the step. Strobes are therefore valid for the full step preceding the edge.
- `mclk_en` low: no state change; outputs hold the current step's word.
- `i_opcode` must be stable from the edge ending T1 until the end of the instruction. Its value in T0/T1 is ignored.
- `o_su` must not glitch into T3 of SUB. `o_fi` is asserted only in ADD/SUB T4.

## Test plan
- **Reset:** assert `reset` with `mclk_en`=0 for one edge → `o_step`=0, `o_co`=`o_mi`=1, `o_hlt`=0, all other outputs 0.
- **LDA then ADD, `mclk_en`=1 every cycle:**
  - LDA: `o_step` sequence 0,1,2,3,0, with ro+ai at step 3.
  - ADD: steps 0,1,2,3,4,0, with eo+ai+fi at step 4 and `o_su`=0 throughout.
  - SUB (0011): `o_su`=1 only at step 4.
- **JC:**
  - `i_carry`=1 → `o_j`=1 and `o_io`=1 at step 2.
  - `i_carry`=0 → `o_j`=0 and `o_io`=1 at step 2.
  - Both cases return to step 0 on the next edge. Repeat for JZ/`i_zero`.
- **`mclk_en` pattern 1,0,0,1,0,1 during LDI:** step advances only on enabled edges (0→1, then 1→2, then 2→0); outputs hold between them.
- **HLT:**
  - After step 2 of opcode 1111: `o_hlt`=1, `o_step`=0, all other outputs 0 for 20 enabled cycles with changing `i_opcode`.
  - Then `reset` → T0 word, and fetch resumes.
- **Reset at step 3 of ADD:** next edge gives `o_step`=0 and the T0 word, with no `o_fi` pulse. Undefined opcode 1010 runs 3 steps with an all-zero T2.

Source files
------------

// File: rtl/sap1_sequencer.sv
// SAP-1 micro-step sequencer and control-word decoder.
// Walks T0..T4 per instruction and decodes the IR opcode into datapath strobes.
module sap1_sequencer #(
    parameter int unsigned STEP_W = 3
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              mclk_en,
    input  logic [3:0]        i_opcode,
    input  logic              i_carry,
    input  logic              i_zero,
    output logic              o_co,
    output logic              o_mi,
    output logic              o_ro,
    output logic              o_ri,
    output logic              o_ii,
    output logic              o_io,
    output logic              o_ai,
    output logic              o_ao,
    output logic              o_bi,
    output logic              o_eo,
    output logic              o_su,
    output logic              o_fi,
    output logic              o_ce,
    output logic              o_j,
    output logic              o_oi,
    output logic              o_hlt,
    output logic [STEP_W-1:0] o_step
);

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    typedef struct packed {
        logic co, mi, ro, ri, ii, io, ai, ao;
        logic bi, eo, su, fi, ce, j, oi, hlt;
    } ctrl_t;

    step_t step_q, step_d, last_step;
    logic  halted_q, halted_d;
    ctrl_t ctrl;

    // State register; reset wins over the clock enable.
    always_ff @(posedge mclk) begin
        if (reset) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (mclk_en) begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Control word decode and next-step selection.
    always_comb begin
        ctrl      = '0;
        step_d    = step_q;
        halted_d  = halted_q;
        last_step = T2;

        case (i_opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase

        if (halted_q) begin
            ctrl.hlt = 1'b1;
        end else begin
            case (step_q)
                T0: begin
                    ctrl.co = 1'b1;
                    ctrl.mi = 1'b1;
                end
                T1: begin
                    ctrl.ro = 1'b1;
                    ctrl.ii = 1'b1;
                    ctrl.ce = 1'b1;
                end
                T2: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl.io = 1'b1;
                            ctrl.mi = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl.io = 1'b1;
                            ctrl.ai = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl.io = 1'b1;
                            ctrl.j  = 1'b1;
                        end
                        OP_JC: begin
                            ctrl.io = 1'b1;
                            ctrl.j  = i_carry;
                        end
                        OP_JZ: begin
                            ctrl.io = 1'b1;
                            ctrl.j  = i_zero;
                        end
                        OP_OUT: begin
                            ctrl.ao = 1'b1;
                            ctrl.oi = 1'b1;
                        end
                        OP_HLT:  ctrl.hlt = 1'b1;
                        default: ctrl = '0;
                    endcase
                end
                T3: begin
                    case (i_opcode)
                        OP_LDA: begin
                            ctrl.ro = 1'b1;
                            ctrl.ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ro = 1'b1;
                            ctrl.bi = 1'b1;
                        end
                        OP_STA: begin
                            ctrl.ao = 1'b1;
                            ctrl.ri = 1'b1;
                        end
                        default: ctrl = '0;
                    endcase
                end
                T4: begin
                    if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                        ctrl.eo = 1'b1;
                        ctrl.ai = 1'b1;
                        ctrl.fi = 1'b1;
                        ctrl.su = (i_opcode == OP_SUB);
                    end
                end
                default: ctrl = '0;
            endcase

            // last_step is never below T2, so fetch steps always advance.
            if (step_q >= last_step) begin
                step_d = T0;
            end else begin
                step_d = step_t'(step_q + 3'd1);
            end

            if (step_q == T2 && i_opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end
    end

    assign o_co   = ctrl.co;
    assign o_mi   = ctrl.mi;
    assign o_ro   = ctrl.ro;
    assign o_ri   = ctrl.ri;
    assign o_ii   = ctrl.ii;
    assign o_io   = ctrl.io;
    assign o_ai   = ctrl.ai;
    assign o_ao   = ctrl.ao;
    assign o_bi   = ctrl.bi;
    assign o_eo   = ctrl.eo;
    assign o_su   = ctrl.su;
    assign o_fi   = ctrl.fi;
    assign o_ce   = ctrl.ce;
    assign o_j    = ctrl.j;
    assign o_oi   = ctrl.oi;
    assign o_hlt  = ctrl.hlt;
    assign o_step = STEP_W'(step_q);

endmodule

// File: tb/tb_sap1_sequencer.sv
// Directed self-checking bench for sap1_sequencer.
// Control outputs are compared as one 16-bit word: {co,mi,ro,ri,ii,io,ai,ao,bi,eo,su,fi,ce,j,oi,hlt}.
module tb_sap1_sequencer;

    localparam int unsigned STEP_W = 3;

    localparam logic [15:0] CO  = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RO  = 16'h2000;
    localparam logic [15:0] RI  = 16'h1000;
    localparam logic [15:0] II  = 16'h0800;
    localparam logic [15:0] IO  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] BI  = 16'h0080;
    localparam logic [15:0] EO  = 16'h0040;
    localparam logic [15:0] SU  = 16'h0020;
    localparam logic [15:0] FI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] J   = 16'h0004;
    localparam logic [15:0] OI  = 16'h0002;
    localparam logic [15:0] HLT = 16'h0001;
    localparam logic [15:0] W_T0 = CO | MI;
    localparam logic [15:0] W_T1 = RO | II | CE;

    logic              mclk;
    logic              reset;
    logic              mclk_en;
    logic [3:0]        opcode;
    logic              carry;
    logic              zero;
    logic              co, mi, ro, ri, ii, io, ai, ao;
    logic              bi, eo, su, fi, ce, j, oi, hlt;
    logic [STEP_W-1:0] step;
    logic [15:0]       word;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]        op;
        logic              c;
        logic              z;
        logic [2:0]        len;
        logic [0:4][15:0]  w;
    } ins_t;

    sap1_sequencer #(.STEP_W(STEP_W)) dut (
        .mclk     (mclk),
        .reset    (reset),
        .mclk_en  (mclk_en),
        .i_opcode (opcode),
        .i_carry  (carry),
        .i_zero   (zero),
        .o_co     (co),
        .o_mi     (mi),
        .o_ro     (ro),
        .o_ri     (ri),
        .o_ii     (ii),
        .o_io     (io),
        .o_ai     (ai),
        .o_ao     (ao),
        .o_bi     (bi),
        .o_eo     (eo),
        .o_su     (su),
        .o_fi     (fi),
        .o_ce     (ce),
        .o_j      (j),
        .o_oi     (oi),
        .o_hlt    (hlt),
        .o_step   (step)
    );

    assign word = {co, mi, ro, ri, ii, io, ai, ao, bi, eo, su, fi, ce, j, oi, hlt};

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic test_reset();
        reset   = 1'b1;
        mclk_en = 1'b0;
        opcode  = 4'h2;
        @(posedge mclk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (step !== 3'd0) begin
            errors++;
            $display("FAIL reset_step got %0d want 0", step);
        end
        checks++;
        if (word !== W_T0) begin
            errors++;
            $display("FAIL reset_word got %h want %h", word, W_T0);
        end
    endtask

    // Each row runs one full instruction from T0; the next row's T0 check proves the wrap.
    task automatic test_instructions();
        ins_t prog [14];
        prog[0]  = '{op: 4'h1, c: 1'b0, z: 1'b0, len: 3'd4, w: '{W_T0, W_T1, IO | MI, RO | AI, 16'h0}};
        prog[1]  = '{op: 4'h2, c: 1'b1, z: 1'b1, len: 3'd5, w: '{W_T0, W_T1, IO | MI, RO | BI, EO | AI | FI}};
        prog[2]  = '{op: 4'h3, c: 1'b0, z: 1'b0, len: 3'd5, w: '{W_T0, W_T1, IO | MI, RO | BI, EO | AI | FI | SU}};
        prog[3]  = '{op: 4'h7, c: 1'b1, z: 1'b0, len: 3'd3, w: '{W_T0, W_T1, IO | J, 16'h0, 16'h0}};
        prog[4]  = '{op: 4'h7, c: 1'b0, z: 1'b1, len: 3'd3, w: '{W_T0, W_T1, IO, 16'h0, 16'h0}};
        prog[5]  = '{op: 4'h8, c: 1'b0, z: 1'b1, len: 3'd3, w: '{W_T0, W_T1, IO | J, 16'h0, 16'h0}};
        prog[6]  = '{op: 4'h8, c: 1'b1, z: 1'b0, len: 3'd3, w: '{W_T0, W_T1, IO, 16'h0, 16'h0}};
        prog[7]  = '{op: 4'h6, c: 1'b0, z: 1'b0, len: 3'd3, w: '{W_T0, W_T1, IO | J, 16'h0, 16'h0}};
        prog[8]  = '{op: 4'h4, c: 1'b0, z: 1'b0, len: 3'd4, w: '{W_T0, W_T1, IO | MI, AO | RI, 16'h0}};
        prog[9]  = '{op: 4'h5, c: 1'b0, z: 1'b0, len: 3'd3, w: '{W_T0, W_T1, IO | AI, 16'h0, 16'h0}};
        prog[10] = '{op: 4'hE, c: 1'b0, z: 1'b0, len: 3'd3, w: '{W_T0, W_T1, AO | OI, 16'h0, 16'h0}};
        prog[11] = '{op: 4'h0, c: 1'b1, z: 1'b1, len: 3'd3, w: '{W_T0, W_T1, 16'h0, 16'h0, 16'h0}};
        prog[12] = '{op: 4'hA, c: 1'b1, z: 1'b1, len: 3'd3, w: '{W_T0, W_T1, 16'h0, 16'h0, 16'h0}};
        prog[13] = '{op: 4'hC, c: 1'b0, z: 1'b0, len: 3'd3, w: '{W_T0, W_T1, 16'h0, 16'h0, 16'h0}};
        mclk_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < int'(prog[i].len); k++) begin
                // Opcode during T0 is garbage: it must be ignored.
                opcode = (k == 0) ? ~prog[i].op : prog[i].op;
                carry  = prog[i].c;
                zero   = prog[i].z;
                #1;
                checks++;
                if (step !== 3'(k)) begin
                    errors++;
                    $display("FAIL instr%0d_op%h_step got %0d want %0d", i, prog[i].op, step, k);
                end
                checks++;
                if (word !== prog[i].w[k]) begin
                    errors++;
                    $display("FAIL instr%0d_op%h_T%0d_word got %h want %h", i, prog[i].op, k, word, prog[i].w[k]);
                end
                @(posedge mclk);
                #1;
            end
        end
        #1;
        checks++;
        if (step !== 3'd0) begin
            errors++;
            $display("FAIL instr_final_wrap got %0d want 0", step);
        end
    endtask

    task automatic test_clock_enable();
        int          pat [6];
        int          exp_step [6];
        logic [15:0] exp_word [6];
        pat      = '{1, 0, 0, 1, 0, 1};
        exp_step = '{1, 1, 1, 2, 2, 0};
        exp_word = '{W_T1, W_T1, W_T1, IO | AI, IO | AI, W_T0};
        opcode = 4'h5;
        carry  = 1'b0;
        zero   = 1'b0;
        for (int e = 0; e < 6; e++) begin
            mclk_en = pat[e][0];
            @(posedge mclk);
            #1;
            checks++;
            if (step !== 3'(exp_step[e])) begin
                errors++;
                $display("FAIL clken_edge%0d_step got %0d want %0d", e, step, exp_step[e]);
            end
            checks++;
            if (word !== exp_word[e]) begin
                errors++;
                $display("FAIL clken_edge%0d_word got %h want %h", e, word, exp_word[e]);
            end
        end
        mclk_en = 1'b1;
    endtask

    task automatic test_reset_mid_add();
        opcode  = 4'h2;
        mclk_en = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge mclk);
            #1;
        end
        checks++;
        if (step !== 3'd3 || word !== (RO | BI)) begin
            errors++;
            $display("FAIL midadd_T3 got step %0d word %h want step 3 word %h", step, word, RO | BI);
        end
        reset = 1'b1;
        @(posedge mclk);
        #1;
        reset = 1'b0;
        checks++;
        if (step !== 3'd0) begin
            errors++;
            $display("FAIL midadd_reset_step got %0d want 0", step);
        end
        checks++;
        if (word !== W_T0) begin
            errors++;
            $display("FAIL midadd_reset_word got %h want %h", word, W_T0);
        end
        @(posedge mclk);
        #1;
        checks++;
        if (step !== 3'd1 || word !== W_T1) begin
            errors++;
            $display("FAIL midadd_resume got step %0d word %h want step 1 word %h", step, word, W_T1);
        end
        @(posedge mclk);
        #1;
        opcode = 4'hA;
        @(posedge mclk);
        #1;
    endtask

    task automatic test_halt();
        mclk_en = 1'b1;
        opcode  = 4'hF;
        @(posedge mclk);
        #1;
        @(posedge mclk);
        #1;
        checks++;
        if (step !== 3'd2 || word !== HLT) begin
            errors++;
            $display("FAIL halt_T2 got step %0d word %h want step 2 word %h", step, word, HLT);
        end
        @(posedge mclk);
        #1;
        for (int c = 0; c < 20; c++) begin
            opcode = 4'(c);
            carry  = c[0];
            zero   = c[1];
            #1;
            checks++;
            if (step !== 3'd0 || word !== HLT) begin
                errors++;
                $display("FAIL halted_cyc%0d got step %0d word %h want step 0 word %h", c, step, word, HLT);
            end
            @(posedge mclk);
            #1;
        end
        reset = 1'b1;
        @(posedge mclk);
        #1;
        reset = 1'b0;
        checks++;
        if (step !== 3'd0 || word !== W_T0) begin
            errors++;
            $display("FAIL halt_reset got step %0d word %h want step 0 word %h", step, word, W_T0);
        end
        opcode = 4'h1;
        @(posedge mclk);
        #1;
        checks++;
        if (step !== 3'd1 || word !== W_T1) begin
            errors++;
            $display("FAIL halt_refetch got step %0d word %h want step 1 word %h", step, word, W_T1);
        end
    endtask

    initial begin
        reset   = 1'b0;
        mclk_en = 1'b0;
        opcode  = 4'h0;
        carry   = 1'b0;
        zero    = 1'b0;
        test_reset();
        test_instructions();
        test_clock_enable();
        test_reset_mid_add();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
